// File: rtl/attempt_sequencer.sv
// -----------------------------------------------------------------------------
// attempt_sequencer
//
// Purpose:
//   Sequences the key_checker block across repeated unlock attempts.
//   - Between attempts, key_checker is held in reset (chk_rst=1) for at least
//     CLEAR_CYCLES cycles. It is released only once no button is pressed, so a
//     held key cannot leak into the next attempt.
//   - Counts consecutive failures. After MAX_FAILS failures it enters a timed
//     lockout.
//   - Latches the unlocked condition until an explicit relock request.
//
// Optional feature (compile-time macro ATTEMPT_SEQUENCER_BACKOFF_EN):
//   Each lockout since the last success or relock doubles the lockout length:
//   LOCK_CYCLES << lockout_count, with the shift capped at 4. The lockout
//   timer gains 4 bits to hold the longest duration. Without the macro, every
//   lockout lasts exactly LOCK_CYCLES cycles.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   btn_any       in   high while any KEY button is pressed
//   chk_success   in   key_checker success output
//   chk_fail      in   key_checker fail output
//   relock        in   single-cycle request to leave UNLOCKED
//   chk_rst       out  active-high reset into key_checker (low only in ARMED)
//   unlocked      out  high in UNLOCKED
//   locked_out    out  high in LOCKOUT
//   fail_cnt      out  consecutive failures, saturating at MAX_FAILS
//   attempt_done  out  one-cycle pulse when an attempt resolves
//   state_dbg     out  current FSM state encoding (debug/observability)
//
// All outputs are registered and are derived from the next state. A state
// change therefore shows on the outputs one cycle after the input that caused
// it was sampled.
// -----------------------------------------------------------------------------
module attempt_sequencer #(
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_CYCLES  = 250000000,
  parameter int CLEAR_CYCLES = 4,
  parameter int FAIL_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_any,
  input  logic              chk_success,
  input  logic              chk_fail,
  input  logic              relock,
  output logic              chk_rst,
  output logic              unlocked,
  output logic              locked_out,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic              attempt_done,
  output logic [1:0]        state_dbg
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
`ifdef ATTEMPT_SEQUENCER_BACKOFF_EN
  // Four extra bits hold LOCK_CYCLES shifted left by up to 4.
  localparam int TIMER_W = $clog2(LOCK_CYCLES + 1) + 4;
`else
  localparam int TIMER_W = $clog2(LOCK_CYCLES + 1);
`endif

  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] LOCK_LEN   = TIMER_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_ARMED    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e              state_q,        state_d;
  logic [CNT_W-1:0]    cnt_q,          cnt_d;
  logic [TIMER_W-1:0]  timer_q,        timer_d;
  logic [FAIL_W-1:0]   fail_cnt_q,     fail_cnt_d;
  logic                chk_rst_q,      chk_rst_d;
  logic                unlocked_q,     unlocked_d;
  logic                locked_out_q,   locked_out_d;
  logic                attempt_done_q, attempt_done_d;

  // Lockout length for the lockout being entered this cycle.
  logic [TIMER_W-1:0]  lock_len;

`ifdef ATTEMPT_SEQUENCER_BACKOFF_EN
  // ---------------------------------------------------------------------------
  // Exponential back-off
  //   lo_cnt_q counts lockouts since the last success or relock. It saturates
  //   at 7. The current count selects the length of the lockout being entered,
  //   so the first lockout lasts LOCK_CYCLES.
  // ---------------------------------------------------------------------------
  logic [2:0] lo_cnt_q, lo_cnt_d;
  logic [2:0] lo_shift;

  always_comb begin
    lo_shift = (lo_cnt_q > 3'd4) ? 3'd4 : lo_cnt_q;
    lock_len = LOCK_LEN << lo_shift;
  end

  always_comb begin
    lo_cnt_d = lo_cnt_q;
    if (state_q == ST_ARMED && state_d == ST_LOCKOUT) begin
      if (lo_cnt_q != 3'd7) begin
        lo_cnt_d = lo_cnt_q + 3'd1;
      end
    end else if (state_q == ST_ARMED && state_d == ST_UNLOCKED) begin
      lo_cnt_d = 3'd0;
    end else if (state_q == ST_UNLOCKED && state_d == ST_CLEAR) begin
      // Leaving UNLOCKED only happens through relock.
      lo_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_cnt_q <= 3'd0;
    end else begin
      lo_cnt_q <= lo_cnt_d;
    end
  end
`else
  always_comb begin
    lock_len = LOCK_LEN;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    fail_cnt_d     = fail_cnt_q;
    attempt_done_d = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // The counter stops at 0. After that, only a released button lets
        // the attempt start. Checker outputs are stale here and are dropped.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!btn_any) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (chk_success) begin
          // Success takes priority when both checker outputs are high.
          state_d        = ST_UNLOCKED;
          fail_cnt_d     = '0;
          attempt_done_d = 1'b1;
        end else if (chk_fail) begin
          attempt_done_d = 1'b1;
          // fail_cnt_q stays below MAX_FAILS while ARMED, so this sum cannot
          // wrap. The >= keeps the counter saturated even if it somehow does.
          if ((fail_cnt_q + FAIL_W'(1)) >= FAIL_MAX) begin
            state_d    = ST_LOCKOUT;
            fail_cnt_d = FAIL_MAX;
            timer_d    = lock_len - TIMER_W'(1);
          end else begin
            state_d    = ST_CLEAR;
            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
            cnt_d      = CNT_RELOAD;
          end
        end
      end

      ST_UNLOCKED: begin
        // Checker outputs are ignored. key_checker is held frozen in reset.
        if (relock) begin
          state_d    = ST_CLEAR;
          fail_cnt_d = '0;
          cnt_d      = CNT_RELOAD;
        end
      end

      ST_LOCKOUT: begin
        // Ignores every input. The timer is loaded with length-1 on entry,
        // and the exit fires on the cycle it reads 0. That gives exactly
        // `length` cycles in LOCKOUT.
        if (timer_q == '0) begin
          state_d    = ST_CLEAR;
          fail_cnt_d = '0;
          cnt_d      = CNT_RELOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = CNT_RELOAD;
      end
    endcase

    // Registered outputs follow the next state so they line up with it.
    chk_rst_d    = (state_d != ST_ARMED);
    unlocked_d   = (state_d == ST_UNLOCKED);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_CLEAR;
      cnt_q          <= CNT_RELOAD;
      timer_q        <= '0;
      fail_cnt_q     <= '0;
      chk_rst_q      <= 1'b1;
      unlocked_q     <= 1'b0;
      locked_out_q   <= 1'b0;
      attempt_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      fail_cnt_q     <= fail_cnt_d;
      chk_rst_q      <= chk_rst_d;
      unlocked_q     <= unlocked_d;
      locked_out_q   <= locked_out_d;
      attempt_done_q <= attempt_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign chk_rst      = chk_rst_q;
  assign unlocked     = unlocked_q;
  assign locked_out   = locked_out_q;
  assign fail_cnt     = fail_cnt_q;
  assign attempt_done = attempt_done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_attempt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_attempt_sequencer
//
// Self-checking bench for attempt_sequencer.
// Parameters: MAX_FAILS=3, LOCK_CYCLES=10, CLEAR_CYCLES=2.
//
// Each cycle, a stimulus word {btn_any, chk_success, chk_fail, relock} is
// applied and the expected output word is pushed into exp_q. After the next
// clock edge, the observed outputs
//   {chk_rst, unlocked, locked_out, fail_cnt[3:0], attempt_done}
// are compared against the popped entry.
// -----------------------------------------------------------------------------
module tb_attempt_sequencer;

  logic       clk;
  logic       rst;
  logic       btn_any;
  logic       chk_success;
  logic       chk_fail;
  logic       relock;
  logic       chk_rst;
  logic       unlocked;
  logic       locked_out;
  logic [3:0] fail_cnt;
  logic       attempt_done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  attempt_sequencer #(
    .MAX_FAILS   (3),
    .LOCK_CYCLES (10),
    .CLEAR_CYCLES(2),
    .FAIL_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_any     (btn_any),
    .chk_success (chk_success),
    .chk_fail    (chk_fail),
    .relock      (relock),
    .chk_rst     (chk_rst),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt),
    .attempt_done(attempt_done),
    .state_dbg   (state_dbg)
  );

  // Expected output word: {chk_rst, unlocked, locked_out, fail_cnt, attempt_done}.
  function automatic logic [7:0] ev(input logic cr, input logic un, input logic lo,
                                    input logic [3:0] fc, input logic ad);
    return {cr, un, lo, fc, ad};
  endfunction

  function automatic logic [7:0] obs();
    return {chk_rst, unlocked, locked_out, fail_cnt, attempt_done};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [3:0] s, input logic [7:0] want);
    {btn_any, chk_success, chk_fail, relock} = s;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    rst = 1'b1;
    {btn_any, chk_success, chk_fail, relock} = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== ev(1, 0, 0, 4'd0, 0)) begin
      $display("FAIL reset_outputs: got %b want %b", obs(), ev(1, 0, 0, 4'd0, 0));
      n_fail++;
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", state_dbg);
      n_fail++;
    end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    st = '{4'b0000, 4'b0000, 4'b0000};
    ex = '{ev(1, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL reset_release step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_fail_count();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    // Steps 4-5 inject stale checker pulses while in CLEAR; they must be dropped.
    st = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
    ex = '{ev(1, 0, 0, 4'd1, 1), ev(1, 0, 0, 4'd1, 0), ev(0, 0, 0, 4'd1, 0),
           ev(1, 0, 0, 4'd2, 1), ev(1, 0, 0, 4'd2, 0), ev(0, 0, 0, 4'd2, 0),
           ev(0, 0, 0, 4'd2, 0)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL fail_count step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_lockout();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    // Third failure: locked_out must stay high for exactly 10 observations,
    // while relock, btn_any and checker pulses are ignored.
    st.push_back(4'b0010);
    ex.push_back(ev(1, 0, 1, 4'd3, 1));
    st = {st, 4'b0001, 4'b1000, 4'b0100, 4'b0011, 4'b0001, 4'b0000, 4'b0000,
          4'b0000, 4'b0001};
    for (int k = 0; k < 9; k++) ex.push_back(ev(1, 0, 1, 4'd3, 0));
    st = {st, 4'b0000, 4'b0000, 4'b0000};
    ex = {ex, ev(1, 0, 0, 4'd0, 0), ev(1, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL lockout step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_success_relock();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    st = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b1100,
           4'b0001, 4'b0000, 4'b0000};
    ex = '{ev(1, 0, 0, 4'd1, 1), ev(1, 0, 0, 4'd1, 0), ev(0, 0, 0, 4'd1, 0),
           ev(0, 0, 0, 4'd1, 0),  // relock outside UNLOCKED: no effect
           ev(1, 1, 0, 4'd0, 1),  // success wins over simultaneous fail
           ev(1, 1, 0, 4'd0, 0), ev(1, 1, 0, 4'd0, 0),
           ev(1, 0, 0, 4'd0, 0), ev(1, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL success_relock step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_btn_hold();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    st.push_back(4'b0010);
    ex.push_back(ev(1, 0, 0, 4'd1, 1));
    for (int k = 0; k < 20; k++) begin
      st.push_back(4'b1000);
      ex.push_back(ev(1, 0, 0, 4'd1, 0));
    end
    st.push_back(4'b0000);
    ex.push_back(ev(0, 0, 0, 4'd1, 0));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL btn_hold step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    logic [7:0] want;
    logic [3:0] st[$];
    logic [7:0] ex[$];
    // fail_cnt is 1 here; two more failures reach lockout.
    st = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    ex = '{ev(1, 0, 0, 4'd2, 1), ev(1, 0, 0, 4'd2, 0), ev(0, 0, 0, 4'd2, 0),
           ev(1, 0, 1, 4'd3, 1), ev(1, 0, 1, 4'd3, 0), ev(1, 0, 1, 4'd3, 0),
           ev(1, 0, 1, 4'd3, 0), ev(1, 0, 1, 4'd3, 0)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL async_pre step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
    // Mid-cycle, during the 5th lockout cycle: reset must act without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== ev(1, 0, 0, 4'd0, 0)) begin
      $display("FAIL async_reset_outputs: got %b want %b", obs(), ev(1, 0, 0, 4'd0, 0));
      n_fail++;
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      $display("FAIL async_reset_state: got %0d want 0", state_dbg);
      n_fail++;
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    st = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    ex = '{ev(1, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0), ev(0, 0, 0, 4'd0, 0),
           ev(1, 0, 0, 4'd1, 1)};
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      got  = obs();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        $display("FAIL async_post step %0d: got %b want %b", i, got, want);
        n_fail++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fail_count();
    test_lockout();
    test_success_relock();
    test_btn_hold();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the bench has no open-ended waits, but never allow a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/attempt_sequencer.md
Name: attempt_sequencer

Overview:
- Controller that sequences the key_checker block across repeated unlock attempts.
- Holds key_checker in reset between attempts, counts consecutive failures, and enforces a timed lockout after MAX_FAILS failures.
- Latches the unlocked condition until an explicit relock.
- Sits in top between the user-interface reset/switch logic and key_checker; all outputs drive LEDs/GPIO or key_checker's rst.

Parameters:
- MAX_FAILS, 3, consecutive failures that trigger lockout (>=1).
- LOCK_CYCLES, 250000000, lockout duration in clk cycles (5 s at 50 MHz).
- CLEAR_CYCLES, 4, minimum cycles chk_rst is held between attempts (>=1).
- FAIL_W, 4, width of fail_cnt; must hold MAX_FAILS.

Ports:
- clk  input  1  system clock (CLK_50).
- rst  input  1  asynchronous, active-low reset.
- btn_any  input  1  high while any KEY button is pressed.
- chk_success  input  1  success output of key_checker.
- chk_fail  input  1  fail output of key_checker.
- relock  input  1  single-cycle request to leave UNLOCKED.
- chk_rst  output  1  active-high reset driven into key_checker.
- unlocked  output  1  high in UNLOCKED.
- locked_out  output  1  high in LOCKOUT.
- fail_cnt  output  FAIL_W  consecutive failures since the last success, lockout expiry, or relock.
- attempt_done  output  1  one-cycle pulse when an attempt resolves (success or fail).

Behaviour:
- Reset (rst low, asynchronous):
  - state=CLEAR, clear counter=CLEAR_CYCLES-1, chk_rst=1.
  - unlocked=0, locked_out=0, fail_cnt=0, attempt_done=0, lock timer=0.
- All outputs are registered. A state change is visible one cycle after the triggering input is sampled.
- States: CLEAR, ARMED, UNLOCKED, LOCKOUT.
- CLEAR:
  - chk_rst=1.
  - Counter decrements to 0 and then holds.
  - Go to ARMED when counter==0 and btn_any==0. A held button keeps the block in CLEAR indefinitely.
- ARMED:
  - chk_rst=0; key_checker runs.
  - chk_success=1: go to UNLOCKED, fail_cnt<=0, attempt_done pulse.
  - chk_fail=1 (and chk_success=0): attempt_done pulse.
    - If fail_cnt+1==MAX_FAILS: go to LOCKOUT, fail_cnt<=MAX_FAILS, timer<=LOCK_CYCLES-1.
    - Otherwise: fail_cnt<=fail_cnt+1, go to CLEAR, counter<=CLEAR_CYCLES-1.
  - chk_success and chk_fail together: success wins.
- UNLOCKED:
  - chk_rst=1, which freezes key_checker. unlocked=1.
  - chk_success/chk_fail are ignored.
  - relock=1: go to CLEAR, fail_cnt<=0, counter reloaded.
- LOCKOUT:
  - chk_rst=1, locked_out=1.
  - Timer decrements by 1 per cycle. relock, btn_any and checker outputs are ignored.
  - At timer==0: fail_cnt<=0, go to CLEAR, counter reloaded. Lockout length is exactly LOCK_CYCLES cycles.
- Width rules:
  - Timer width is $clog2(LOCK_CYCLES+1).
  - Clear counter width is $clog2(CLEAR_CYCLES+1).
  - fail_cnt never wraps; it saturates at MAX_FAILS.
- relock outside UNLOCKED has no effect.
- Reset asserted mid-lockout or mid-attempt aborts immediately to reset values; no lockout state is retained.
- chk_success/chk_fail are sampled only in ARMED. Stale pulses in CLEAR are discarded.

Optional Feature:
- Macro: ATTEMPT_SEQUENCER_BACKOFF_EN.
- Defined:
  - An extra lockout-count register (saturating 3 bits, reset 0) counts lockouts since the last success or relock.
  - Lockout duration is LOCK_CYCLES<<lockout_count, with the shift capped at 4.
  - The timer is widened by 4 bits.
  - lockout_count increments on each LOCKOUT entry and clears on UNLOCKED entry or relock.
- Undefined: every lockout lasts exactly LOCK_CYCLES; the extra register is absent.

Test Plan:
All scenarios use MAX_FAILS=3, LOCK_CYCLES=10, CLEAR_CYCLES=2.
- Reset release, btn_any=0 -> chk_rst=1 for 2 cycles, then chk_rst=0 (ARMED); all other outputs 0.
- ARMED, chk_fail pulse -> attempt_done 1 cycle, fail_cnt=1, chk_rst=1 for 2 cycles, then ARMED; repeat once -> fail_cnt=2.
- Third chk_fail -> locked_out=1, fail_cnt=3, chk_rst=1 for exactly 10 cycles; then locked_out=0, fail_cnt=0, CLEAR, ARMED. Pulsing relock mid-lockout changes nothing.
- ARMED, chk_success and chk_fail in the same cycle -> unlocked=1, fail_cnt=0, chk_rst=1; relock pulse -> unlocked=0, CLEAR, then ARMED.
- btn_any held high through CLEAR for 20 cycles -> chk_rst stays 1; release -> ARMED next cycle.
- rst low asynchronously during cycle 5 of lockout -> outputs return to reset values without waiting for a clk edge; after release, fail_cnt=0, normal CLEAR→ARMED.
